// File: rtl/fetch_rd_arbiter.sv
// Shares one in-order read port between fetch (inst) and load (data), routing responses through a tag FIFO.
// Optional ARB_RR_EN selects round-robin arbitration instead of fixed data-over-inst priority.
module fetch_rd_arbiter #(
    parameter int OST_DEPTH = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        inst_req_i,
    input  logic [ADDR_W-1:0]           inst_addr_i,
    input  logic                        inst_cancel_i,
    output logic                        inst_addr_ok_o,
    output logic                        inst_data_ok_o,
    output logic [31:0]                 inst_rdata_o,
    input  logic                        data_req_i,
    input  logic [ADDR_W-1:0]           data_addr_i,
    input  logic [1:0]                  data_size_i,
    output logic                        data_addr_ok_o,
    output logic                        data_data_ok_o,
    output logic [31:0]                 data_rdata_o,
    output logic                        rd_req_o,
    output logic [ADDR_W-1:0]           rd_addr_o,
    output logic [1:0]                  rd_size_o,
    input  logic                        rd_addr_ok_i,
    input  logic                        rd_data_ok_i,
    input  logic [31:0]                 rd_rdata_i,
    output logic [$clog2(OST_DEPTH):0]  ost_cnt_o,
    output logic                        ost_err_o
);
    localparam int PW = $clog2(OST_DEPTH);
    localparam int CW = PW + 1;

    // Tag FIFO: owner bit (1 = data) and discard bit per entry.
    logic [OST_DEPTH-1:0] owner_q, discard_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q;
    logic                 lock_q, lock_d;
    logic                 lock_data_q;
`ifdef ARB_RR_EN
    logic                 last_data_q;
`endif

    logic full, grant_data, granted_req, push, pop;
    logic head_owner, head_discard;

    assign full = (cnt_q == CW'(OST_DEPTH));

    always_comb begin
        grant_data = data_req_i;
        if (lock_q) begin
            grant_data = lock_data_q;
        end
`ifdef ARB_RR_EN
        else if (data_req_i && inst_req_i) begin
            grant_data = !last_data_q;
        end
`endif
    end

    // A locked grant only requests on behalf of its owner; if the owner drops, nothing is issued.
    assign granted_req = grant_data ? data_req_i : inst_req_i;
    assign rd_req_o    = !full && granted_req;
    assign rd_addr_o   = rd_req_o ? (grant_data ? data_addr_i : inst_addr_i) : '0;
    assign rd_size_o   = rd_req_o ? (grant_data ? data_size_i : 2'b10) : 2'b00;

    assign push = rd_req_o && rd_addr_ok_i;
    assign pop  = rd_data_ok_i && (cnt_q != '0);

    assign inst_addr_ok_o = push && !grant_data;
    assign data_addr_ok_o = push && grant_data;

    assign head_owner   = owner_q[rd_ptr_q];
    assign head_discard = discard_q[rd_ptr_q] || (inst_cancel_i && !head_owner);

    assign data_data_ok_o = pop && head_owner;
    assign inst_data_ok_o = pop && !head_owner && !head_discard;
    assign inst_rdata_o   = rd_rdata_i;
    assign data_rdata_o   = rd_rdata_i;

    assign ost_cnt_o = cnt_q;
    assign ost_err_o = err_q;

    assign cnt_d  = cnt_q + CW'(push) - CW'(pop);
    // Cancel releases an inst lock so fetch may present the redirected address next cycle.
    assign lock_d = rd_req_o && !rd_addr_ok_i && !(inst_cancel_i && !grant_data);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            owner_q     <= '0;
            discard_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            lock_q      <= 1'b0;
            lock_data_q <= 1'b0;
        end else begin
            for (int i = 0; i < OST_DEPTH; i++) begin
                if (push && (wr_ptr_q == PW'(i))) begin
                    owner_q[i]   <= grant_data;
                    discard_q[i] <= 1'b0;
                end else if (inst_cancel_i && !owner_q[i]) begin
                    discard_q[i] <= 1'b1;
                end
            end
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q       <= cnt_d;
            lock_q      <= lock_d;
            lock_data_q <= grant_data;
            if (rd_data_ok_i && (cnt_q == '0)) err_q <= 1'b1;
        end
    end

`ifdef ARB_RR_EN
    // Remembers the last accepted owner; reset value points at inst so data wins the first contention.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_data_q <= 1'b0;
        end else if (push) begin
            last_data_q <= grant_data;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_rd_arbiter.sv
// Directed bench for fetch_rd_arbiter; define ARB_RR_EN to also exercise round-robin grants.
module tb_fetch_rd_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_cancel, data_req;
    logic [31:0] inst_addr, data_addr;
    logic [1:0]  data_size;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        rd_req, rd_addr_ok, rd_data_ok;
    logic [31:0] rd_addr, rd_rdata;
    logic [1:0]  rd_size;
    logic [2:0]  ost_cnt;
    logic        ost_err;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    fetch_rd_arbiter #(.OST_DEPTH(4), .ADDR_W(32)) dut (
        .clk_i(clk), .reset_i(reset),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_cancel_i(inst_cancel),
        .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok), .inst_rdata_o(inst_rdata),
        .data_req_i(data_req), .data_addr_i(data_addr), .data_size_i(data_size),
        .data_addr_ok_o(data_addr_ok), .data_data_ok_o(data_data_ok), .data_rdata_o(data_rdata),
        .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_size_o(rd_size),
        .rd_addr_ok_i(rd_addr_ok), .rd_data_ok_i(rd_data_ok), .rd_rdata_i(rd_rdata),
        .ost_cnt_o(ost_cnt), .ost_err_o(ost_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge, then settle inputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; inst_req = 0; inst_cancel = 0; data_req = 0;
        inst_addr = 0; data_addr = 0; data_size = 0;
        rd_addr_ok = 0; rd_data_ok = 0; rd_rdata = 0;
        repeat (2) @(negedge clk);
        settle();
        check("rst_cnt", ost_cnt, 0);
        check("rst_err", ost_err, 0);
        check("rst_rdreq", rd_req, 0);
        check("rst_addr", rd_addr, 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: both request, data wins, inst next; responses D then I
        inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; data_size = 2'b01; rd_addr_ok = 1;
        settle();
        check("t1_rdreq", rd_req, 1);
        check("t1_daok", data_addr_ok, 1);
        check("t1_iaok", inst_addr_ok, 0);
        check("t1_addr", rd_addr, 32'h200);
        check("t1_size", rd_size, 2'b01);
        tick();
        data_req = 0;
        settle();
        check("t1_iaok2", inst_addr_ok, 1);
        check("t1_addr2", rd_addr, 32'h100);
        check("t1_size2", rd_size, 2'b10);
        tick();
        inst_req = 0; rd_addr_ok = 0;
        settle();
        check("t1_cnt", ost_cnt, 2);
        rd_data_ok = 1; rd_rdata = 32'hD0;
        settle();
        check("t1_ddok", data_data_ok, 1);
        check("t1_idok0", inst_data_ok, 0);
        check("t1_drdata", data_rdata, 32'hD0);
        tick();
        rd_rdata = 32'h10;
        settle();
        check("t1_idok", inst_data_ok, 1);
        check("t1_ddok0", data_data_ok, 0);
        check("t1_irdata", inst_rdata, 32'h10);
        tick();
        rd_data_ok = 0;
        settle();
        check("t1_cnt0", ost_cnt, 0);

        // 2: inst waits three cycles locked; later data request must not steal the grant
        inst_req = 1; inst_addr = 32'h300;
        settle();
        check("t2_rdreq", rd_req, 1);
        check("t2_iaok0", inst_addr_ok, 0);
        repeat (3) tick();
        data_req = 1; data_addr = 32'h400; data_size = 2'b00;
        settle();
        check("t2_lockaddr", rd_addr, 32'h300);
        check("t2_daok0", data_addr_ok, 0);
        rd_addr_ok = 1;
        settle();
        check("t2_iaok", inst_addr_ok, 1);
        check("t2_daok1", data_addr_ok, 0);
        tick();
        inst_req = 0;
        settle();
        check("t2_daok", data_addr_ok, 1);
        check("t2_daddr", rd_addr, 32'h400);
        tick();
        data_req = 0; rd_addr_ok = 0;
        rd_data_ok = 1;
        settle();
        check("t2_first_inst", inst_data_ok, 1);
        tick();
        settle();
        check("t2_second_data", data_data_ok, 1);
        tick();
        rd_data_ok = 0;
        settle();
        check("t2_cnt0", ost_cnt, 0);

        // 3: fill the FIFO, full blocks issue even when popping the same cycle
        inst_req = 1; inst_addr = 32'h500; rd_addr_ok = 1;
        repeat (4) tick();
        settle();
        check("t3_full_cnt", ost_cnt, 4);
        check("t3_full_rdreq", rd_req, 0);
        check("t3_full_iaok", inst_addr_ok, 0);
        rd_data_ok = 1;
        settle();
        check("t3_pop_idok", inst_data_ok, 1);
        check("t3_nobypass", rd_req, 0);
        tick();
        rd_data_ok = 0;
        settle();
        check("t3_cnt3", ost_cnt, 3);
        check("t3_rdreq_back", rd_req, 1);
        inst_req = 0;
        tick();
        rd_data_ok = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_drain_idok", inst_data_ok, 1);
            tick();
        end
        rd_data_ok = 0;
        settle();
        check("t3_cnt0", ost_cnt, 0);

        // 4: cancel with two inst in flight while a redirected inst is accepted
        inst_req = 1; inst_addr = 32'h600; rd_addr_ok = 1;
        repeat (2) tick();
        inst_addr = 32'h700; inst_cancel = 1;
        settle();
        check("t4_push_cancel", inst_addr_ok, 1);
        tick();
        inst_req = 0; inst_cancel = 0; rd_addr_ok = 0;
        settle();
        check("t4_cnt", ost_cnt, 3);
        rd_data_ok = 1;
        settle();
        check("t4_drop1", inst_data_ok, 0);
        tick();
        settle();
        check("t4_drop2", inst_data_ok, 0);
        tick();
        settle();
        check("t4_keep", inst_data_ok, 1);
        tick();
        rd_data_ok = 0;

        // 4b: data entry survives cancel; inst head popping during cancel is suppressed
        data_req = 1; data_addr = 32'h800; rd_addr_ok = 1;
        tick();
        data_req = 0; inst_req = 1; inst_addr = 32'h900;
        tick();
        inst_req = 0; rd_addr_ok = 0;
        inst_cancel = 1;
        settle();
        check("t4b_cnt", ost_cnt, 2);
        tick();
        inst_cancel = 0; rd_data_ok = 1;
        settle();
        check("t4b_data_kept", data_data_ok, 1);
        tick();
        settle();
        check("t4b_inst_drop", inst_data_ok, 0);
        tick();
        inst_req = 1; inst_addr = 32'hA00; rd_addr_ok = 1; rd_data_ok = 0;
        tick();
        inst_req = 0; rd_addr_ok = 0;
        rd_data_ok = 1; inst_cancel = 1;
        settle();
        check("t4b_head_cancel", inst_data_ok, 0);
        tick();
        rd_data_ok = 0; inst_cancel = 0;
        settle();
        check("t4b_cnt0", ost_cnt, 0);
        check("t4b_noerr", ost_err, 0);

        // 5: stray response on an empty FIFO
        rd_data_ok = 1;
        settle();
        check("t5_no_idok", inst_data_ok, 0);
        check("t5_no_ddok", data_data_ok, 0);
        tick();
        rd_data_ok = 0;
        settle();
        check("t5_err", ost_err, 1);
        check("t5_cnt", ost_cnt, 0);
        repeat (3) tick();
        check("t5_err_sticky", ost_err, 1);
        reset = 1;
        settle();
        check("t5_err_clr", ost_err, 0);
        tick();
        reset = 0;
        tick();

`ifdef ARB_RR_EN
        // 6: continuous contention alternates D,I,D,I
        inst_req = 1; inst_addr = 32'hB00; data_req = 1; data_addr = 32'hC00; rd_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t6_grant_data", data_addr_ok, (i % 2 == 0) ? 1 : 0);
            check("t6_grant_inst", inst_addr_ok, (i % 2 == 0) ? 0 : 1);
            tick();
        end
        inst_req = 0; data_req = 0; rd_addr_ok = 0;
        settle();
        check("t6_cnt", ost_cnt, 4);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
